// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fetch (IF) and load/store (LSU) share one DRAM port,
// one transaction outstanding at a time, with anti-starvation and response timeout.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        owner_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TIMER_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [TIMER_W-1:0]  timer;
    logic                we_q;
    logic [3:0]          be_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic                lsu_wins;
    logic                granted;
    logic [31:0]         resp_data;

    // LSU takes ties until it has won STARVE_LIMIT times in a row over a waiting IF.
    always_comb begin
        lsu_wins  = lsu_req_i && (!if_req_i || (streak != STREAK_MAX));
        resp_data = we_q ? 32'h0 : mem_rdata_i;
    end

    // Grant is combinational with mem_gnt_i; suppressed while reset is asserted.
    assign granted     = (state == REQ) && mem_gnt_i && reset;
    assign if_gnt_o    = granted && !owner_o;
    assign lsu_gnt_o   = granted && owner_o;
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = mem_req_o && we_q;
    assign mem_be_o    = mem_req_o ? be_q : 4'h0;
    assign mem_addr_o  = mem_req_o ? addr_q : 32'h0;
    assign mem_wdata_o = mem_req_o ? wdata_q : 32'h0;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            streak       <= '0;
            timer        <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            owner_o      <= 1'b0;
            err_o        <= 1'b0;
            if_rvalid_o  <= 1'b0;
            if_rdata_o   <= 32'h0;
            lsu_rvalid_o <= 1'b0;
            lsu_rdata_o  <= 32'h0;
        end else begin
            if_rvalid_o  <= 1'b0;
            lsu_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_i || lsu_req_i) begin
                        owner_o <= lsu_wins;
                        we_q    <= lsu_wins ? lsu_we_i : 1'b0;
                        be_q    <= lsu_wins ? lsu_be_i : 4'hF;
                        addr_q  <= lsu_wins ? lsu_addr_i : if_addr_i;
                        wdata_q <= lsu_wins ? lsu_wdata_i : 32'h0;
                        if (lsu_wins && if_req_i)
                            streak <= streak + 1'b1;
                        else
                            streak <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        timer <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid_i || (timer == TIMER_LAST)) begin
                        if (owner_o) begin
                            lsu_rvalid_o <= 1'b1;
                            lsu_rdata_o  <= mem_rvalid_i ? resp_data : 32'hDEADBEEF;
                        end else begin
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= mem_rvalid_i ? resp_data : 32'hDEADBEEF;
                        end
                        if (!mem_rvalid_i)
                            err_o <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: inputs change 1ns after
// each rising edge, outputs are checked 2ns after it.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        owner_o;
    logic        busy_o;
    logic        err_o;

    int compared   = 0;
    int mismatched = 0;

    mem_port_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic lsuReq, input logic lsuWe,
                                 input logic [3:0] lsuBe, input logic [31:0] lsuAddr,
                                 input logic [31:0] lsuWdata);
        if_req_i    = ifReq;
        if_addr_i   = ifAddr;
        lsu_req_i   = lsuReq;
        lsu_we_i    = lsuWe;
        lsu_be_i    = lsuBe;
        lsu_addr_i  = lsuAddr;
        lsu_wdata_i = lsuWdata;
    endtask

    task automatic memDrive(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        mem_gnt_i    = gnt;
        mem_rvalid_i = rvalid;
        mem_rdata_i  = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [4:0] expOrder;
        expOrder = 5'b10111;

        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_mem_req", mem_req_o, 0);
        checkOutput("rst_owner", owner_o, 0);
        checkOutput("rst_if_rdata", if_rdata_o, 0);
        checkOutput("rst_lsu_rdata", lsu_rdata_o, 0);
        reset = 1'b1;

        $display("[TB] IF-only read");
        nextCycle();
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b0, 32'h0);
        checkOutput("if_t0_mem_req", mem_req_o, 0);
        nextCycle();
        memDrive(1'b1, 1'b0, 32'h0);
        checkOutput("if_t1_mem_req", mem_req_o, 1);
        checkOutput("if_t1_addr", mem_addr_o, 32'h10);
        checkOutput("if_t1_we", mem_we_o, 0);
        checkOutput("if_t1_be", mem_be_o, 4'hF);
        checkOutput("if_t1_if_gnt", if_gnt_o, 1);
        checkOutput("if_t1_lsu_gnt", lsu_gnt_o, 0);
        checkOutput("if_t1_busy", busy_o, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b1, 32'h00500093);
        checkOutput("if_t2_mem_req", mem_req_o, 0);
        checkOutput("if_t2_if_rvalid", if_rvalid_o, 0);
        nextCycle();
        memDrive(1'b0, 1'b0, 32'h0);
        checkOutput("if_t3_if_rvalid", if_rvalid_o, 1);
        checkOutput("if_t3_if_rdata", if_rdata_o, 32'h00500093);
        checkOutput("if_t3_lsu_rvalid", lsu_rvalid_o, 0);
        checkOutput("if_t3_busy", busy_o, 0);
        nextCycle();
        checkOutput("if_t4_if_rvalid", if_rvalid_o, 0);
        checkOutput("if_t4_if_rdata", if_rdata_o, 32'h00500093);

        $display("[TB] starvation order");
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
        memDrive(1'b1, 1'b1, 32'hCAFE0000);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput($sformatf("arb%0d_owner", i), owner_o, expOrder[i]);
            checkOutput($sformatf("arb%0d_lsu_gnt", i), lsu_gnt_o, expOrder[i]);
            checkOutput($sformatf("arb%0d_if_gnt", i), if_gnt_o, !expOrder[i]);
            checkOutput($sformatf("arb%0d_addr", i), mem_addr_o,
                        expOrder[i] ? 32'h200 : 32'h100);
            nextCycle();
            nextCycle();
            checkOutput($sformatf("arb%0d_lsu_rvalid", i), lsu_rvalid_o, expOrder[i]);
            checkOutput($sformatf("arb%0d_if_rvalid", i), if_rvalid_o, !expOrder[i]);
        end
        checkOutput("arb_lsu_rdata", lsu_rdata_o, 32'hCAFE0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b0, 32'h0);

        $display("[TB] LSU store");
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'h12345678);
        nextCycle();
        memDrive(1'b1, 1'b0, 32'h0);
        checkOutput("st_we", mem_we_o, 1);
        checkOutput("st_be", mem_be_o, 4'b0011);
        checkOutput("st_addr", mem_addr_o, 32'h40);
        checkOutput("st_wdata", mem_wdata_o, 32'h12345678);
        checkOutput("st_lsu_gnt", lsu_gnt_o, 1);
        checkOutput("st_owner", owner_o, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b1, 32'hFFFFFFFF);
        nextCycle();
        memDrive(1'b0, 1'b0, 32'h0);
        checkOutput("st_lsu_rvalid", lsu_rvalid_o, 1);
        checkOutput("st_lsu_rdata", lsu_rdata_o, 0);
        checkOutput("st_if_rvalid", if_rvalid_o, 0);
        checkOutput("st_if_rdata_held", if_rdata_o, 32'hCAFE0000);

        $display("[TB] withheld grant then timeout");
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        nextCycle();
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("wait%0d_mem_req", k), mem_req_o, 1);
            checkOutput($sformatf("wait%0d_addr", k), mem_addr_o, 32'h80);
            checkOutput($sformatf("wait%0d_be", k), mem_be_o, 4'hF);
            checkOutput($sformatf("wait%0d_if_gnt", k), if_gnt_o, 0);
            nextCycle();
        end
        memDrive(1'b1, 1'b0, 32'h0);
        checkOutput("wait6_if_gnt", if_gnt_o, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 64; k++) begin
            checkOutput($sformatf("to%0d_busy", k), busy_o, 1);
            checkOutput($sformatf("to%0d_err", k), err_o, 0);
            nextCycle();
        end
        checkOutput("to_err", err_o, 1);
        checkOutput("to_if_rvalid", if_rvalid_o, 1);
        checkOutput("to_if_rdata", if_rdata_o, 32'hDEADBEEF);
        checkOutput("to_busy", busy_o, 0);
        memDrive(1'b0, 1'b1, 32'h11111111);
        nextCycle();
        memDrive(1'b0, 1'b0, 32'h0);
        checkOutput("late_if_rvalid", if_rvalid_o, 0);
        checkOutput("late_if_rdata", if_rdata_o, 32'hDEADBEEF);
        checkOutput("late_busy", busy_o, 0);
        checkOutput("late_err", err_o, 1);

        $display("[TB] reset during RESP");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        nextCycle();
        memDrive(1'b1, 1'b0, 32'h0);
        checkOutput("rr_lsu_gnt", lsu_gnt_o, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        memDrive(1'b0, 1'b0, 32'h0);
        checkOutput("rr_busy_resp", busy_o, 1);
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        memDrive(1'b0, 1'b1, 32'h22222222);
        checkOutput("rr_busy", busy_o, 0);
        checkOutput("rr_mem_req", mem_req_o, 0);
        checkOutput("rr_err", err_o, 0);
        checkOutput("rr_owner", owner_o, 0);
        checkOutput("rr_lsu_rvalid", lsu_rvalid_o, 0);
        checkOutput("rr_if_rdata", if_rdata_o, 0);
        nextCycle();
        memDrive(1'b0, 1'b0, 32'h0);
        checkOutput("rr_late_lsu_rvalid", lsu_rvalid_o, 0);
        checkOutput("rr_late_lsu_rdata", lsu_rdata_o, 0);
        checkOutput("rr_late_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
